// File: rtl/mult4_acc_pkg.sv
// Shared constants and helpers for the 4x4 multiply-accumulate stage.
package mult4_acc_pkg;

    localparam int          OP_W     = 4;
    localparam int          PROD_W   = 8;
    localparam logic [7:0]  MAX_PROD = 8'd225;

    // Saturating increment: stays at max_val once reached.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
        if (cnt >= max_val) begin
            return max_val;
        end
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/mult4_core.sv
// Combinational unsigned 4x4 multiplier built from four 2x2 partial products.
// Any other 4x4 implementation with the same ports can replace this module.
module mult4_core (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);

    logic [3:0] pp_ll;
    logic [3:0] pp_hl;
    logic [3:0] pp_lh;
    logic [3:0] pp_hh;

    // 2x2 partial products, recombined with shifts of 0, 2, 2 and 4.
    always_comb begin
        pp_ll = {2'b00, A[1:0]} * {2'b00, B[1:0]};
        pp_hl = {2'b00, A[3:2]} * {2'b00, B[1:0]};
        pp_lh = {2'b00, A[1:0]} * {2'b00, B[3:2]};
        pp_hh = {2'b00, A[3:2]} * {2'b00, B[3:2]};
        P     = {4'b0000, pp_ll}
              + {2'b00, pp_hl, 2'b00}
              + {2'b00, pp_lh, 2'b00}
              + {pp_hh, 4'b0000};
    end

endmodule

// File: rtl/mult4_acc_stage.sv
// Streaming multiply-accumulate stage: registered operand stage (S1),
// multiply + accumulate stage (S2), registered frame result with valid/ready.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// in_ready depends only on the output stall, never on in_valid.
// Control state is implicit: IDLE (no s1_valid, no out_valid), ACCUM (s1_valid),
// HOLD (out_valid with out_ready low, which freezes the whole pipe).
module mult4_acc_stage
    import mult4_acc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int               SUM_W   = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [OP_W-1:0]   s1_a_q, s1_a_d;
    logic [OP_W-1:0]   s1_b_q, s1_b_d;
    logic              s1_last_q, s1_last_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_valid_q, out_valid_d;

    logic              stall;
    logic              accept;
    logic              fire;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt_n;
    logic              new_ovf;

    mult4_core u_mult (
        .A (s1_a_q),
        .B (s1_b_q),
        .P (prod)
    );

    // Stall and input handshake; ready is forced low while reset is asserted.
    always_comb begin
        stall    = out_valid_q & ~out_ready;
        in_ready = rst_n & ~stall;
        accept   = in_valid & in_ready;
        fire     = ~stall & s1_valid_q;
    end

    // S1 operand register: capture on accept, drain when free, hold on stall.
    always_comb begin
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_last_d  = s1_last_q;
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_last_d  = in_last;
            s1_valid_d = 1'b1;
        end else if (!stall) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 accumulate, frame close and output register update.
    always_comb begin
        sum         = {1'b0, acc_q} + SUM_W'(prod);
        cnt_n       = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
        new_ovf     = sum[ACC_W] | (cnt_q == CNT_MAX);
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q & ~out_ready;
        if (fire) begin
            if (!s1_last_q) begin
                acc_d = sum[ACC_W-1:0];
                cnt_d = cnt_n;
                ovf_d = ovf_q | new_ovf;
            end else begin
                out_acc_d   = sum[ACC_W-1:0];
                out_count_d = cnt_n;
                out_ovf_d   = ovf_q | new_ovf;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_last_q   <= s1_last_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output ports driven straight from registers.
    always_comb begin
        out_valid = out_valid_q;
        out_acc   = out_acc_q;
        out_count = out_count_q;
        out_ovf   = out_ovf_q;
    end

endmodule

// File: tb/tb_mult4_acc_stage.sv
// Bench for mult4_acc_stage: three instances (default, ACC_W=8, CNT_W=2) share
// one input stream; a frame-level arithmetic model predicts every result.
module tb_mult4_acc_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic in_last;
  logic out_ready;

  logic d_in_ready, d_out_valid, d_out_ovf;
  logic [15:0] d_out_acc;
  logic [7:0] d_out_count;
  logic w_in_ready, w_out_valid, w_out_ovf;
  logic [7:0] w_out_acc;
  logic [7:0] w_out_count;
  logic c_in_ready, c_out_valid, c_out_ovf;
  logic [15:0] c_out_acc;
  logic [1:0] c_out_count;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mult4_acc_stage #(.ACC_W(16), .CNT_W(8)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(d_out_valid),
    .out_ready(out_ready), .out_acc(d_out_acc), .out_count(d_out_count), .out_ovf(d_out_ovf)
  );
  mult4_acc_stage #(.ACC_W(8), .CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_acc(w_out_acc), .out_count(w_out_count), .out_ovf(w_out_ovf)
  );
  mult4_acc_stage #(.ACC_W(16), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_acc(c_out_acc), .out_count(c_out_count), .out_ovf(c_out_ovf)
  );

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];    // true (unbounded) frame sums
  logic [31:0] exp_n_q[$];  // true beat counts
  int cur_sum = 0;
  int cur_n = 0;

  function automatic logic [31:0] m_acc(input logic [31:0] s, input int w);
    return s & ((32'd1 << w) - 32'd1);
  endfunction
  function automatic logic [31:0] m_cnt(input logic [31:0] n, input int cw);
    logic [31:0] mx = (32'd1 << cw) - 32'd1;
    return (n > mx) ? mx : n;
  endfunction
  function automatic logic [31:0] m_ovf(input logic [31:0] s, input logic [31:0] n, input int w, input int cw);
    return 32'((s >= (32'd1 << w)) || (n > ((32'd1 << cw) - 32'd1)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- cycle driver / monitor ----------------
  int cyc = 0;
  int stall_left = 0;
  bit rand_ready = 0;
  int stall_cycles = 0;
  int n_res = 0, first_res_cyc = -1, last_res_cyc = -1, last_acc_cyc = -1;
  bit prev_stall = 0;
  logic [31:0] prev_acc, prev_cnt, prev_ovf;
  logic [31:0] d_acc_r, d_cnt_r, d_ovf_r, w_acc_r, w_ovf_r, c_acc_r, c_cnt_r, c_ovf_r;

  // Called at posedge+#1 with inputs set; checks at negedge, returns at next posedge+#1.
  task automatic tick(output bit accepted);
    logic [31:0] s, n;
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    cyc++;
    accepted = 1'b0;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(d_in_ready | w_in_ready | c_in_ready), 0);
      chk("rst_out_valid", 32'(d_out_valid | w_out_valid | c_out_valid), 0);
      chk("rst_out_acc", 32'(d_out_acc | 16'(w_out_acc) | c_out_acc), 0);
      chk("rst_out_count", 32'(d_out_count | w_out_count | 8'(c_out_count)), 0);
      chk("rst_out_ovf", 32'(d_out_ovf | w_out_ovf | c_out_ovf), 0);
      cur_sum = 0;
      cur_n = 0;
      exp_q.delete();
      exp_n_q.delete();
      prev_stall = 0;
    end else begin
      chk("in_ready_stall", 32'(d_in_ready), 32'(!(d_out_valid && !out_ready)));
      chk("in_ready_same", 32'({w_in_ready, c_in_ready}), 32'({d_in_ready, d_in_ready}));
      if (!d_in_ready) stall_cycles++;
      if (prev_stall) begin
        chk("hold_valid", 32'(d_out_valid), 1);
        chk("hold_acc", 32'(d_out_acc), prev_acc);
        chk("hold_count", 32'(d_out_count), prev_cnt);
        chk("hold_ovf", 32'(d_out_ovf), prev_ovf);
      end
      if (in_valid && d_in_ready) begin
        accepted = 1'b1;
        cur_sum += int'(in_a) * int'(in_b);
        cur_n++;
        if (in_last) begin
          exp_q.push_back(32'(cur_sum));
          exp_n_q.push_back(32'(cur_n));
          cur_sum = 0;
          cur_n = 0;
          last_acc_cyc = cyc;
        end
      end
      if (d_out_valid && out_ready) begin
        n_res++;
        if (first_res_cyc < 0) first_res_cyc = cyc;
        last_res_cyc = cyc;
        chk("others_valid", 32'({w_out_valid, c_out_valid}), 32'(2'b11));
        chk("pending_result", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          s = exp_q.pop_front();
          n = exp_n_q.pop_front();
          chk("d_acc", 32'(d_out_acc), m_acc(s, 16));
          chk("d_count", 32'(d_out_count), m_cnt(n, 8));
          chk("d_ovf", 32'(d_out_ovf), m_ovf(s, n, 16, 8));
          chk("w_acc", 32'(w_out_acc), m_acc(s, 8));
          chk("w_ovf", 32'(w_out_ovf), m_ovf(s, n, 8, 8));
          chk("c_acc", 32'(c_out_acc), m_acc(s, 16));
          chk("c_count", 32'(c_out_count), m_cnt(n, 2));
          chk("c_ovf", 32'(c_out_ovf), m_ovf(s, n, 16, 2));
        end
        d_acc_r = 32'(d_out_acc); d_cnt_r = 32'(d_out_count); d_ovf_r = 32'(d_out_ovf);
        w_acc_r = 32'(w_out_acc); w_ovf_r = 32'(w_out_ovf);
        c_acc_r = 32'(c_out_acc); c_cnt_r = 32'(c_out_count); c_ovf_r = 32'(c_out_ovf);
      end
      prev_stall = d_out_valid && !out_ready;
      prev_acc = 32'(d_out_acc);
      prev_cnt = 32'(d_out_count);
      prev_ovf = 32'(d_out_ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int a, input int b, input bit last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_a = 4'(a);
    in_b = 4'(b);
    in_last = last;
    for (int k = 0; k < 64 && !ok; k++) tick(ok);
    chk("beat_accepted", 32'(ok), 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit dummy;
    in_valid = 1'b0;
    for (int k = 0; k < 300 && (exp_q.size() != 0 || d_out_valid); k++) tick(dummy);
    chk("drain_done", 32'(exp_q.size()), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit dummy;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tick(dummy);
    tick(dummy);
    rst_n = 1'b1;
    tick(dummy);

    // 1: basic frame and latency
    beat(3, 5, 0);
    beat(15, 15, 0);
    beat(2, 7, 1);
    first_res_cyc = -1;
    drain();
    chk("t1_latency", 32'(first_res_cyc - last_acc_cyc), 2);
    chk("t1_acc", d_acc_r, 254);
    chk("t1_count", d_cnt_r, 3);
    chk("t1_ovf", d_ovf_r, 0);

    // 2: exhaustive single-beat frames, one result per cycle
    n_res = 0;
    first_res_cyc = -1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        beat(a, b, 1);
    drain();
    chk("t2_results", 32'(n_res), 256);
    chk("t2_span", 32'(last_res_cyc - first_res_cyc), 255);

    // 3: random frames with random and forced backpressure
    rand_ready = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 30) stall_left = 5;
      if ($urandom_range(0, 7) == 0) begin
        in_valid = 1'b0;
        tick(dummy);
      end
      beat($urandom_range(0, 15), $urandom_range(0, 15), (i == 29) || ($urandom_range(0, 3) == 0));
    end
    beat($urandom_range(0, 15), $urandom_range(0, 15), 1);
    drain();
    chk("t3_stalled", 32'(stall_cycles >= 5), 1);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick(dummy);

    // 4: accumulator wrap in the ACC_W=8 instance, then clean frame
    beat(15, 15, 0);
    beat(15, 15, 1);
    drain();
    chk("t4_w_acc", w_acc_r, 194);
    chk("t4_w_ovf", w_ovf_r, 1);
    chk("t4_d_acc", d_acc_r, 450);
    chk("t4_d_ovf", d_ovf_r, 0);
    beat(1, 1, 1);
    drain();
    chk("t4b_w_acc", w_acc_r, 1);
    chk("t4b_w_ovf", w_ovf_r, 0);

    // 5: count saturation in the CNT_W=2 instance
    for (int i = 0; i < 4; i++) beat(1, 1, 0);
    beat(1, 1, 1);
    drain();
    chk("t5_c_count", c_cnt_r, 3);
    chk("t5_c_ovf", c_ovf_r, 1);
    chk("t5_c_acc", c_acc_r, 5);
    chk("t5_d_count", d_cnt_r, 5);
    chk("t5_d_ovf", d_ovf_r, 0);

    // 6: reset in the middle of a frame
    beat(7, 7, 0);
    rst_n = 1'b0;
    tick(dummy);
    tick(dummy);
    rst_n = 1'b1;
    tick(dummy);
    beat(2, 3, 1);
    drain();
    chk("t6_acc", d_acc_r, 6);
    chk("t6_count", d_cnt_r, 1);
    chk("t6_ovf", d_ovf_r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
